// File: rtl/l2_mem_arbiter.sv
// l2_mem_arbiter
// Shares one slow_memory port between the I-side and D-side L2 caches.
// Round-robin arbitration; the grant is held for one whole block
// transaction and every transaction is followed by at least one idle
// cycle with the memory request lines low.
//
// Ports:
//   clk, proc_reset            clock, asynchronous active-high reset
//   i_read/i_write/i_addr/i_wdata -> i_rdata/i_ready   I-side L2 request
//   d_read/d_write/d_addr/d_wdata -> d_rdata/d_ready   D-side L2 request
//   mem_read/mem_write/mem_addr/mem_wdata -> slow_memory request
//   mem_rdata/mem_ready        slow_memory response
module l2_mem_arbiter #(
   parameter int ADDR_W = 28,
   parameter int DATA_W = 128
) (
   input  logic              clk,
   input  logic              proc_reset,
   input  logic              i_read,
   input  logic              i_write,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [DATA_W-1:0] i_wdata,
   output logic [DATA_W-1:0] i_rdata,
   output logic              i_ready,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_ready,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GNT_I = 2'd1,
      GNT_D = 2'd2
   } state_t;

   state_t state;
   state_t next_state;
   logic   last_gnt;
   logic   hold_off;
   logic   req_i;
   logic   req_d;
   logic   req_i_eff;
   logic   req_d_eff;

   assign req_i = i_read | i_write;
   assign req_d = d_read | d_write;

   // In the first idle cycle after a transaction the side that was just
   // served may still be showing its old request; masking it there keeps
   // that stale request from being granted a second time.
   assign req_i_eff = req_i & ~(hold_off & ~last_gnt);
   assign req_d_eff = req_d & ~(hold_off &  last_gnt);

   // State register, round-robin history, and the post-transaction
   // stale-request mask (set on every exit from a grant state).
   always_ff @(posedge clk or posedge proc_reset) begin
      if (proc_reset) begin
         state    <= IDLE;
         last_gnt <= 1'b0;
         hold_off <= 1'b0;
      end else begin
         state    <= next_state;
         hold_off <= (state != IDLE) && (next_state == IDLE);
         if (state == IDLE && next_state == GNT_I)
            last_gnt <= 1'b0;
         else if (state == IDLE && next_state == GNT_D)
            last_gnt <= 1'b1;
      end
   end

   // Next-state logic: on a tie the side that did not win last time is
   // granted; a grant ends on mem_ready or when the owner drops its request.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (req_i_eff && req_d_eff)
               next_state = last_gnt ? GNT_I : GNT_D;
            else if (req_i_eff)
               next_state = GNT_I;
            else if (req_d_eff)
               next_state = GNT_D;
         end
         GNT_I: begin
            if (mem_ready || !req_i)
               next_state = IDLE;
         end
         GNT_D: begin
            if (mem_ready || !req_d)
               next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Output logic: pure pass-through for the granted side, everything
   // zero otherwise, so an asynchronous reset clears the outputs at once.
   always_comb begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      i_rdata   = '0;
      i_ready   = 1'b0;
      d_rdata   = '0;
      d_ready   = 1'b0;
      case (state)
         GNT_I: begin
            mem_read  = i_read;
            mem_write = i_write;
            mem_addr  = i_addr;
            mem_wdata = i_wdata;
            i_rdata   = mem_rdata;
            i_ready   = mem_ready;
         end
         GNT_D: begin
            mem_read  = d_read;
            mem_write = d_write;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            d_rdata   = mem_rdata;
            d_ready   = mem_ready;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_l2_mem_arbiter.sv
// tb_l2_mem_arbiter
// Directed testbench for l2_mem_arbiter. Each scenario task drives its
// own stimulus and compares outputs against hand-computed values.
// Inputs change 1 time unit after the rising edge; outputs are sampled
// a further unit later, well away from the clock edge.
module tb_l2_mem_arbiter;

   localparam int AW = 28;
   localparam int DW = 128;

   logic          clk;
   logic          proc_reset;
   logic          i_read, i_write, d_read, d_write;
   logic [AW-1:0] i_addr, d_addr, mem_addr;
   logic [DW-1:0] i_wdata, d_wdata, i_rdata, d_rdata, mem_wdata, mem_rdata;
   logic          i_ready, d_ready, mem_read, mem_write, mem_ready;

   int vec_count  = 0;
   int miscompares = 0;

   l2_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .proc_reset(proc_reset),
      .i_read(i_read), .i_write(i_write), .i_addr(i_addr), .i_wdata(i_wdata),
      .i_rdata(i_rdata), .i_ready(i_ready),
      .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_ready(d_ready),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance to 1 unit after the next rising edge.
   task tick();
      @(posedge clk);
      #1;
   endtask

   // Clear all inputs and pulse reset across one rising edge.
   task do_reset();
      proc_reset = 1'b1;
      i_read = 0; i_write = 0; i_addr = '0; i_wdata = '0;
      d_read = 0; d_write = 0; d_addr = '0; d_wdata = '0;
      mem_rdata = '0; mem_ready = 0;
      tick();
      proc_reset = 1'b0;
   endtask

   task test_reset();
      do_reset();
      proc_reset = 1'b1;
      #1;
      if ({mem_read, mem_write, i_ready, d_ready} !== 4'b0000) begin
         $display("FAIL reset_ctrl got %b expected 0000", {mem_read, mem_write, i_ready, d_ready});
         miscompares++;
      end
      vec_count++;
      if ({mem_addr, mem_wdata, i_rdata, d_rdata} !== '0) begin
         $display("FAIL reset_data got addr %h wdata %h irdata %h drdata %h expected all zero",
                  mem_addr, mem_wdata, i_rdata, d_rdata);
         miscompares++;
      end
      vec_count++;
      tick();
      proc_reset = 1'b0;
   endtask

   task test_d_read();
      do_reset();
      d_read = 1; d_addr = 28'h0000010;
      #1;
      if (mem_read !== 1'b0) begin
         $display("FAIL d_read_latency got mem_read %b expected 0", mem_read);
         miscompares++;
      end
      vec_count++;
      tick();
      if ({mem_read, mem_write, mem_addr} !== {2'b10, 28'h0000010}) begin
         $display("FAIL d_read_grant got rd %b wr %b addr %h expected rd 1 wr 0 addr 0000010",
                  mem_read, mem_write, mem_addr);
         miscompares++;
      end
      vec_count++;
      mem_ready = 1; mem_rdata = {16{8'hA5}};
      #1;
      if ({d_ready, i_ready, d_rdata, i_rdata} !== {2'b10, {16{8'hA5}}, 128'h0}) begin
         $display("FAIL d_read_done got dready %b iready %b drdata %h irdata %h expected 1 0 a5..a5 0",
                  d_ready, i_ready, d_rdata, i_rdata);
         miscompares++;
      end
      vec_count++;
      tick();
      mem_ready = 0; d_read = 0;
      #1;
      if ({mem_read, mem_write, d_ready} !== 3'b000) begin
         $display("FAIL d_read_idle got %b expected 000", {mem_read, mem_write, d_ready});
         miscompares++;
      end
      vec_count++;
   endtask

   task test_simultaneous();
      do_reset();
      i_read = 1; i_addr = 28'h4;
      d_write = 1; d_addr = 28'h8; d_wdata = 128'h1234;
      tick();
      if ({mem_read, mem_write, mem_addr, mem_wdata} !== {2'b01, 28'h8, 128'h1234}) begin
         $display("FAIL sim_first_d got rd %b wr %b addr %h wdata %h expected rd 0 wr 1 addr 8 wdata 1234",
                  mem_read, mem_write, mem_addr, mem_wdata);
         miscompares++;
      end
      vec_count++;
      mem_ready = 1;
      #1;
      if ({d_ready, i_ready} !== 2'b10) begin
         $display("FAIL sim_d_ready got d %b i %b expected d 1 i 0", d_ready, i_ready);
         miscompares++;
      end
      vec_count++;
      tick();
      mem_ready = 0; d_write = 0;
      #1;
      if ({mem_read, mem_write} !== 2'b00) begin
         $display("FAIL sim_idle got %b expected 00", {mem_read, mem_write});
         miscompares++;
      end
      vec_count++;
      tick();
      if ({mem_read, mem_write, mem_addr} !== {2'b10, 28'h4}) begin
         $display("FAIL sim_second_i got rd %b wr %b addr %h expected rd 1 wr 0 addr 4",
                  mem_read, mem_write, mem_addr);
         miscompares++;
      end
      vec_count++;
      mem_ready = 1; mem_rdata = 128'hBEEF;
      #1;
      if ({i_ready, d_ready, i_rdata, d_rdata} !== {2'b10, 128'hBEEF, 128'h0}) begin
         $display("FAIL sim_i_ready got iready %b dready %b irdata %h drdata %h expected 1 0 beef 0",
                  i_ready, d_ready, i_rdata, d_rdata);
         miscompares++;
      end
      vec_count++;
      tick();
      mem_ready = 0; i_read = 0;
   endtask

   task test_back_to_back();
      logic          exp_d;
      logic [AW-1:0] exp_addr;
      do_reset();
      i_read = 1; i_addr = 28'h100;
      d_read = 1; d_addr = 28'h200;
      for (int n = 0; n < 6; n++) begin
         exp_d    = (n % 2 == 0);
         exp_addr = exp_d ? 28'h200 : 28'h100;
         tick();
         if ({mem_read, mem_addr} !== {1'b1, exp_addr}) begin
            $display("FAIL b2b_grant%0d got rd %b addr %h expected rd 1 addr %h",
                     n, mem_read, mem_addr, exp_addr);
            miscompares++;
         end
         vec_count++;
         mem_ready = 1;
         #1;
         if ({d_ready, i_ready} !== {exp_d, ~exp_d}) begin
            $display("FAIL b2b_ready%0d got d %b i %b expected d %b i %b",
                     n, d_ready, i_ready, exp_d, ~exp_d);
            miscompares++;
         end
         vec_count++;
         tick();
         mem_ready = 0;
         #1;
         if ({mem_read, mem_write} !== 2'b00) begin
            $display("FAIL b2b_idle%0d got %b expected 00", n, {mem_read, mem_write});
            miscompares++;
         end
         vec_count++;
      end
      i_read = 0; d_read = 0;
      tick();
   endtask

   task test_stale();
      do_reset();
      i_read = 1; i_addr = 28'h30;
      tick();
      mem_ready = 1;
      #1;
      if ({mem_read, i_ready} !== 2'b11) begin
         $display("FAIL stale_first got rd %b iready %b expected 1 1", mem_read, i_ready);
         miscompares++;
      end
      vec_count++;
      tick();
      mem_ready = 0;
      #1;
      if (mem_read !== 1'b0) begin
         $display("FAIL stale_idle got %b expected 0", mem_read);
         miscompares++;
      end
      vec_count++;
      tick();
      i_read = 0;
      #1;
      if (mem_read !== 1'b0) begin
         $display("FAIL stale_regrant got %b expected 0", mem_read);
         miscompares++;
      end
      vec_count++;
      tick();
      i_read = 1; i_addr = 28'h40;
      #1;
      if (mem_read !== 1'b0) begin
         $display("FAIL stale_quiet got %b expected 0", mem_read);
         miscompares++;
      end
      vec_count++;
      tick();
      if ({mem_read, mem_addr} !== {1'b1, 28'h40}) begin
         $display("FAIL stale_fresh got rd %b addr %h expected rd 1 addr 40", mem_read, mem_addr);
         miscompares++;
      end
      vec_count++;
      mem_ready = 1;
      tick();
      mem_ready = 0; i_read = 0;
      tick();
   endtask

   task test_abort();
      do_reset();
      i_read = 1; i_addr = 28'h50;
      tick();
      i_read = 0;
      #1;
      if ({mem_read, mem_write} !== 2'b00) begin
         $display("FAIL abort_drop got %b expected 00", {mem_read, mem_write});
         miscompares++;
      end
      vec_count++;
      tick();
      i_read = 1; d_read = 1; d_addr = 28'h60;
      #1;
      if ({mem_read, i_ready} !== 2'b00) begin
         $display("FAIL abort_idle got rd %b iready %b expected 0 0", mem_read, i_ready);
         miscompares++;
      end
      vec_count++;
      tick();
      if ({mem_read, mem_addr} !== {1'b1, 28'h60}) begin
         $display("FAIL abort_then_d got rd %b addr %h expected rd 1 addr 60", mem_read, mem_addr);
         miscompares++;
      end
      vec_count++;
      mem_ready = 1;
      #1;
      if ({d_ready, i_ready} !== 2'b10) begin
         $display("FAIL abort_d_ready got d %b i %b expected d 1 i 0", d_ready, i_ready);
         miscompares++;
      end
      vec_count++;
      tick();
      mem_ready = 0; i_read = 0; d_read = 0;
      tick();
   endtask

   task test_reset_mid();
      do_reset();
      d_read = 1; d_addr = 28'h70;
      tick();
      mem_ready = 1;
      #1;
      if ({mem_read, d_ready} !== 2'b11) begin
         $display("FAIL midrst_before got rd %b dready %b expected 1 1", mem_read, d_ready);
         miscompares++;
      end
      vec_count++;
      #1;
      proc_reset = 1;
      #1;
      if ({mem_read, mem_write, d_ready, mem_addr} !== {3'b000, 28'h0}) begin
         $display("FAIL midrst_async got rd %b wr %b dready %b addr %h expected 0 0 0 0",
                  mem_read, mem_write, d_ready, mem_addr);
         miscompares++;
      end
      vec_count++;
      #1;
      proc_reset = 0; mem_ready = 0;
      i_read = 1; i_addr = 28'h74;
      tick();
      if ({mem_read, mem_addr} !== {1'b1, 28'h70}) begin
         $display("FAIL midrst_tie got rd %b addr %h expected rd 1 addr 70", mem_read, mem_addr);
         miscompares++;
      end
      vec_count++;
      mem_ready = 1;
      tick();
      mem_ready = 0; i_read = 0; d_read = 0;
      tick();
   endtask

   initial begin
      test_reset();
      test_d_read();
      test_simultaneous();
      test_back_to_back();
      test_stale();
      test_abort();
      test_reset_mid();
      $display("[TB] == %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
      $finish;
   end

endmodule

// File: doc/l2_mem_arbiter.md
Name: l2_mem_arbiter

Overview:
- Shares one slow_memory port between the I-side and D-side L2 caches, so a single backing memory can serve both cache hierarchies.
- Sits between the two cache_L2 mem_* interfaces and one slow_memory instance.
- Uses round-robin arbitration. The grant is held for one whole block transaction (read or write of 128 bits) until the memory returns ready.

Parameters:
- ADDR_W, 28, block address width (byte address bits 31:4).
- DATA_W, 128, block data width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- proc_reset  input  1  asynchronous, active-high reset.
- i_read  input  1  I-side L2 block read request, held until i_ready.
- i_write  input  1  I-side L2 block write request, held until i_ready.
- i_addr  input  ADDR_W  I-side block address.
- i_wdata  input  DATA_W  I-side write data.
- i_rdata  output  DATA_W  I-side read data.
- i_ready  output  1  I-side transaction done (one-cycle pulse).
- d_read, d_write, d_addr, d_wdata, d_rdata, d_ready  same as the i_* ports, for the D side.
- mem_read  output  1  read request to slow_memory.
- mem_write  output  1  write request to slow_memory.
- mem_addr  output  ADDR_W  address to slow_memory.
- mem_wdata  output  DATA_W  write data to slow_memory.
- mem_rdata  input  DATA_W  read data from slow_memory.
- mem_ready  input  1  slow_memory completion.

Behaviour:
- States: IDLE, GNT_I, GNT_D. A 1-bit register last_gnt holds 0 = I, 1 = D.
- Reset (asynchronous, any time including mid-transaction):
  - state = IDLE, last_gnt = 0 (I), so D wins the first tie.
  - mem_read = mem_write = 0, i_ready = d_ready = 0, mem_addr = mem_wdata = 0, i_rdata = d_rdata = 0.
- IDLE:
  - All mem_* request outputs are 0 and both ready outputs are 0.
  - req_i = i_read|i_write; req_d = d_read|d_write.
  - Only req_i -> GNT_I. Only req_d -> GNT_D.
  - Both -> grant the side that is not last_gnt. last_gnt is updated on every grant.
  - Neither -> stay in IDLE.
- GNT_x (combinational pass-through):
  - mem_read = x_read, mem_write = x_write, mem_addr = x_addr, mem_wdata = x_wdata, x_rdata = mem_rdata, x_ready = mem_ready.
  - The non-granted side sees ready = 0 and rdata = 0.
- Leaving GNT_x:
  - mem_ready = 1 -> IDLE at the next edge. The ready pulse reaches only the granted side.
  - Granted side drops both read and write before mem_ready (abort) -> mem_read/mem_write follow to 0 in the same cycle; -> IDLE at the next edge.
  - Otherwise stay in GNT_x.
- Mandatory IDLE cycle:
  - Every completion passes through IDLE for at least one cycle, with memory requests low.
  - This means a requester that still shows read/write in the cycle after its ready is never re-granted on a stale request, and slow_memory always sees a request-low cycle between transactions.
- Latency: one cycle of arbitration. A request first seen in IDLE at edge N appears on mem_* during cycle N+1. Memory latency is added unchanged.
- Fairness: with both sides continuously requesting, grants alternate D, I, D, I, … Maximum wait is one foreign transaction plus two cycles.
- Illegal input: read and write both high on one side is passed through unchanged. The arbiter does not check for it.
- Request changes on the non-granted side while a transaction is in progress have no effect.
- mem_ready while in IDLE is ignored.

Test Plan:
- D-only read: d_read = 1, d_addr = 28'h0000010. Expect mem_read = 1 and mem_addr = 28'h0000010 one cycle later. Memory returns ready with rdata 128'hA5…A5 -> d_ready pulses 1 cycle with d_rdata = A5…A5; i_ready stays 0; next cycle state is IDLE.
- Simultaneous requests after reset: i_read (addr 0x4) and d_write (addr 0x8, wdata 128'h1234) asserted together. D is granted first (mem_write = 1, mem_addr = 0x8). After d_ready and one IDLE cycle, I is granted (mem_read = 1, mem_addr = 0x4).
- Back-to-back fairness: both sides requesting continuously for 6 transactions -> grant order D, I, D, I, D, I. Every mem_ready is followed by exactly one cycle with mem_read = mem_write = 0.
- Stale request: I holds i_read one cycle past i_ready while D is idle -> no second memory request is issued for that stale cycle. mem_read stays 0 until a fresh request is seen after the IDLE cycle.
- Abort: during GNT_I, i_read drops before mem_ready -> mem_read = 0 in the same cycle, state IDLE at the next edge. A later d_read is granted normally.
- Reset mid-transaction: proc_reset asserted between clock edges while in GNT_D -> mem_read, mem_write, d_ready drop immediately without waiting for an edge. After release, a tie grants D first.
